// File: rtl/write_request_buffer.sv
// Write-request FIFO feeding the register-file write decoder: accepts (addr, data)
// over valid/ready, issues the head entry as Addr/we/wr_data, with hold and flush.
module write_request_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 4,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  hold,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] Addr,
  output logic                  we,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty
);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_d [DEPTH];
  logic                  push_s;
  logic                  pop_s;

  // Handshake, issue outputs and next-state computation.
  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    empty    = (count_q == {CNT_W{1'b0}});
    in_ready = ~full;
    count    = count_q;
    push_s   = in_valid & in_ready & ~flush;
    pop_s    = ~empty & ~hold & ~flush;
    we       = pop_s;

    if (empty) begin
      Addr    = {ADDR_WIDTH{1'b0}};
      wr_data = {DATA_WIDTH{1'b0}};
    end else begin
      Addr    = addr_mem_q[rd_ptr_q];
      wr_data = data_mem_q[rd_ptr_q];
    end

    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (flush) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        addr_mem_d[wr_ptr_q] = in_addr;
        data_mem_d[wr_ptr_q] = in_data;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is not reset; contents are only visible through count.
  always_ff @(posedge clk) begin
    addr_mem_q <= addr_mem_d;
    data_mem_q <= data_mem_d;
  end

endmodule
